cpu_block_xfer: RTL and testbench

//  Parametrised register<->memory block-move engine for the Chip-8/SCHIP CPU: executes Fx55/Fx65 (V0..Vx to/from RAM at I)
//  and Fx75/Fx85 (V0..Vx to/from RPL flags) as one started job. Sits beside the register file and RAM port; the CPU
//  FSM pulses start, then waits for done. Adds pipelined reads with configurable RAM latency, the I-increment quirk,
//  and a range check on RPL jobs.

---
 rtl/cpu_block_xfer_pkg.sv | 37 +++
 rtl/cpu_block_xfer_if.sv | 44 ++++
 rtl/cpu_block_xfer_rpl_store.sv | 23 ++
 rtl/cpu_block_xfer.sv | 169 ++++++++++++++++
 tb/tb_cpu_block_xfer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_block_xfer_pkg.sv
// Shared op codes, FSM states and op helpers for the
// register<->memory block-move engine.
package cpu_block_xfer_pkg;

    localparam logic [1:0] XFER_ST_MEM = 2'd0;
    localparam logic [1:0] XFER_LD_MEM = 2'd1;
    localparam logic [1:0] XFER_ST_RPL = 2'd2;
    localparam logic [1:0] XFER_LD_RPL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_MEM,
        S_LD_MEM,
        S_ST_RPL,
        S_LD_RPL,
        S_DONE
    } xfer_state_e;

    // RPL ops share op[1]=1, MEM ops op[1]=0
    function automatic logic is_rpl_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic xfer_state_e op_state(input logic [1:0] op);
        xfer_state_e s;
        s = S_IDLE;
        unique case (1'b1)
            op == XFER_ST_MEM: s = S_ST_MEM;
            op == XFER_LD_MEM: s = S_LD_MEM;
            op == XFER_ST_RPL: s = S_ST_RPL;
            op == XFER_LD_RPL: s = S_LD_RPL;
            default:           s = S_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_block_xfer_if.sv
// Job, register-file, RAM and I-writeback signals between the
// CPU (master) and the block-move engine (slave).
interface cpu_block_xfer_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 16,
    parameter int ADDR_W = 12
);
    localparam int RIDX_W = $clog2(NREG);

    logic              start;
    logic [1:0]        op;
    logic [RIDX_W-1:0] last_reg;
    logic [ADDR_W-1:0] base_addr;
    logic              inc_i;
    logic              busy;
    logic              done;
    logic              error;
    logic [RIDX_W-1:0] reg_idx;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              ram_en;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              i_we;
    logic [ADDR_W-1:0] i_new;

    modport master (
        output start, op, last_reg, base_addr, inc_i,
        output reg_rdata, ram_rdata,
        input  busy, done, error, reg_idx, reg_we, reg_wdata,
        input  ram_en, ram_wr, ram_addr, ram_wdata, i_we, i_new
    );

    modport slave (
        input  start, op, last_reg, base_addr, inc_i,
        input  reg_rdata, ram_rdata,
        output busy, done, error, reg_idx, reg_we, reg_wdata,
        output ram_en, ram_wr, ram_addr, ram_wdata, i_we, i_new
    );

endinterface

// File: rtl/cpu_block_xfer_rpl_store.sv
// RPL flag array: one sync write port, one async read port.
// Deliberately not reset so flags survive a CPU reset.
module cpu_rpl_store #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_block_xfer.sv
// Block-move engine: V0..Vx to/from RAM at I or the RPL flags,
// with pipelined RAM reads of configurable latency.
module cpu_block_xfer
    import cpu_block_xfer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NREG      = 16,
    parameter int ADDR_W    = 12,
    parameter int RD_LAT    = 1,
    parameter int RPL_DEPTH = 8
) (
    input logic             clk,
    input logic             res_n,
    cpu_block_xfer_if.slave bus
);
    localparam int RIDX_W = $clog2(NREG);
    localparam int PIDX_W = (RPL_DEPTH > 1) ? $clog2(RPL_DEPTH) : 1;
    localparam int RL_W   = RIDX_W + 1;
    localparam logic [RL_W-1:0]   RPL_LIM = RL_W'(RPL_DEPTH);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [RIDX_W-1:0] R_ONE   = RIDX_W'(1);

    xfer_state_e       state_q;
    logic [RIDX_W-1:0] last_q, cnt_q, reg_idx_q;
    logic [ADDR_W-1:0] base_q, ram_addr_q, i_new_q;
    logic              inc_q, busy_q, done_q, error_q, i_we_q;
    logic              ram_en_q, ram_wr_q, reg_we_q;
    logic              line_v_q [RD_LAT];
    logic [RIDX_W-1:0] line_i_q [RD_LAT];

    logic              wb_v;
    logic [RIDX_W-1:0] wb_idx;
    logic              rpl_we;
    logic [DATA_W-1:0] rpl_rdata;

    assign wb_v   = line_v_q[RD_LAT-1];
    assign wb_idx = line_i_q[RD_LAT-1];
    assign rpl_we = (state_q == S_ST_RPL);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= S_IDLE;
            last_q     <= '0;
            cnt_q      <= '0;
            reg_idx_q  <= '0;
            base_q     <= '0;
            ram_addr_q <= '0;
            i_new_q    <= '0;
            inc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            i_we_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                line_v_q[i] <= 1'b0;
                line_i_q[i] <= '0;
            end
        end else begin
            // read-return line: one slot per cycle of RAM latency
            for (int i = RD_LAT - 1; i > 0; i--) begin
                line_v_q[i] <= line_v_q[i-1];
                line_i_q[i] <= line_i_q[i-1];
            end
            line_v_q[0] <= (state_q == S_LD_MEM) && ram_en_q;
            line_i_q[0] <= cnt_q;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        last_q     <= bus.last_reg;
                        base_q     <= bus.base_addr;
                        inc_q      <= bus.inc_i && !is_rpl_op(bus.op);
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        reg_idx_q  <= '0;
                        ram_addr_q <= bus.base_addr;
                        if (is_rpl_op(bus.op) &&
                            {1'b0, bus.last_reg} >= RPL_LIM) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q  <= op_state(bus.op);
                            ram_en_q <= !is_rpl_op(bus.op);
                            ram_wr_q <= (bus.op == XFER_ST_MEM);
                            reg_we_q <= (bus.op == XFER_LD_RPL);
                        end
                    end
                end
                S_ST_MEM, S_ST_RPL, S_LD_RPL: begin
                    if (cnt_q == last_q) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        i_we_q   <= inc_q;
                        i_new_q  <= inc_q ?
                            base_q + ADDR_W'(last_q) + A_ONE : '0;
                        ram_en_q <= 1'b0;
                        ram_wr_q <= 1'b0;
                        reg_we_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q + R_ONE;
                        reg_idx_q  <= cnt_q + R_ONE;
                        ram_addr_q <= ram_addr_q + A_ONE;
                    end
                end
                S_LD_MEM: begin
                    if (ram_en_q) begin
                        if (cnt_q == last_q) begin
                            ram_en_q <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + R_ONE;
                            ram_addr_q <= ram_addr_q + A_ONE;
                        end
                    end
                    if (wb_v && wb_idx == last_q) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        i_we_q   <= inc_q;
                        i_new_q  <= inc_q ?
                            base_q + ADDR_W'(last_q) + A_ONE : '0;
                        ram_en_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                    i_we_q     <= 1'b0;
                    i_new_q    <= '0;
                    reg_idx_q  <= '0;
                    ram_addr_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    cpu_rpl_store #(
        .DATA_W (DATA_W),
        .DEPTH  (RPL_DEPTH),
        .IDX_W  (PIDX_W)
    ) u_rpl (
        .clk     (clk),
        .we_i    (rpl_we),
        .waddr_i (reg_idx_q[PIDX_W-1:0]),
        .wdata_i (bus.reg_rdata),
        .raddr_i (reg_idx_q[PIDX_W-1:0]),
        .rdata_o (rpl_rdata)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.i_we      = i_we_q;
    assign bus.i_new     = i_new_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = (ram_en_q && ram_wr_q) ? bus.reg_rdata : '0;
    assign bus.reg_idx   = wb_v ? wb_idx : reg_idx_q;
    assign bus.reg_we    = wb_v | reg_we_q;
    assign bus.reg_wdata = wb_v     ? bus.ram_rdata :
                           reg_we_q ? rpl_rdata     : '0;

endmodule

// File: tb/tb_cpu_block_xfer.sv
// Directed bench for cpu_block_xfer with register-file and
// RAM models and scoreboard queues for write traffic.
`timescale 1ns/1ps
module tb_cpu_block_xfer;
    import cpu_block_xfer_pkg::*;

    localparam int DATA_W    = 8;
    localparam int NREG      = 16;
    localparam int ADDR_W    = 12;
    localparam int RD_LAT    = 3;
    localparam int RPL_DEPTH = 8;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    cpu_block_xfer_if #(
        .DATA_W (DATA_W), .NREG (NREG), .ADDR_W (ADDR_W)
    ) bus ();

    cpu_block_xfer #(
        .DATA_W    (DATA_W),
        .NREG      (NREG),
        .ADDR_W    (ADDR_W),
        .RD_LAT    (RD_LAT),
        .RPL_DEPTH (RPL_DEPTH)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus.slave)
    );

    logic [7:0]  rf   [NREG];
    logic [7:0]  mem  [4096];
    logic [7:0]  pipe [RD_LAT];
    logic        tb_rwe = 1'b0;
    logic        tb_mwe = 1'b0;
    logic [3:0]  tb_ridx = '0;
    logic [11:0] tb_maddr = '0;
    logic [7:0]  tb_d = '0;

    assign bus.reg_rdata = rf[bus.reg_idx];
    assign bus.ram_rdata = pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (bus.reg_we) rf[bus.reg_idx] <= bus.reg_wdata;
        else if (tb_rwe) rf[tb_ridx] <= tb_d;
        if (bus.ram_en && bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
        else if (tb_mwe) mem[tb_maddr] <= tb_d;
        pipe[0] <= mem[bus.ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    int errors = 0;
    int checks = 0;
    logic [19:0] ramq [$];
    logic [11:0] regq [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int i, input logic [7:0] d);
        tb_ridx = 4'(i);
        tb_d    = d;
        tb_rwe  = 1'b1;
        @(negedge clk);
        tb_rwe  = 1'b0;
    endtask

    task automatic set_mem(input logic [11:0] a, input logic [7:0] d);
        tb_maddr = a;
        tb_d     = d;
        tb_mwe   = 1'b1;
        @(negedge clk);
        tb_mwe   = 1'b0;
    endtask

    function automatic logic [7:0] rpl_val(input int k);
        return 8'(8'hC3 ^ (k * 17));
    endfunction

    // Start a job, return cycle of done (0 = first busy cycle)
    task automatic run_job(input logic [1:0] op, input logic [3:0] x,
                           input logic [11:0] base, input logic inc,
                           output int cyc, output logic err,
                           output logic iwe, output logic [11:0] inew);
        bus.op        = op;
        bus.last_reg  = x;
        bus.base_addr = base;
        bus.inc_i     = inc;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_on", 32'(bus.busy), 1);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        err  = bus.error;
        iwe  = bus.i_we;
        inew = bus.i_new;
        @(negedge clk);
        chk("idle_after", 32'(bus.busy), 0);
    endtask

    int          cyc;
    logic        err, iwe;
    logic [11:0] inew;
    logic [7:0]  acc;

    initial begin
        bus.start     = 1'b0;
        bus.op        = '0;
        bus.last_reg  = '0;
        bus.base_addr = '0;
        bus.inc_i     = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (res_n && bus.ram_en && bus.ram_wr) begin
                    chk("ram_pending", 32'(ramq.size() != 0), 1);
                    if (ramq.size() != 0)
                        chk("ram_wr", {12'd0, bus.ram_addr, bus.ram_wdata},
                            {12'd0, ramq.pop_front()});
                end
                if (res_n && bus.reg_we) begin
                    chk("reg_pending", 32'(regq.size() != 0), 1);
                    if (regq.size() != 0)
                        chk("reg_wr", {20'd0, bus.reg_idx, bus.reg_wdata},
                            {20'd0, regq.pop_front()});
                end
            end
        join_none

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_done_err", {29'd0, bus.busy, bus.done, bus.error}, 0);
        chk("rst_strobes", {29'd0, bus.ram_en, bus.reg_we, bus.i_we}, 0);
        chk("rst_addr", {8'd0, bus.ram_addr, bus.i_new}, 0);
        res_n = 1'b1;
        @(negedge clk);

        // ST_MEM x=2 at 0x300
        set_reg(0, 8'd11);
        set_reg(1, 8'd22);
        set_reg(2, 8'd33);
        ramq.push_back({12'h300, 8'd11});
        ramq.push_back({12'h301, 8'd22});
        ramq.push_back({12'h302, 8'd33});
        run_job(XFER_ST_MEM, 4'd2, 12'h300, 1'b0, cyc, err, iwe, inew);
        chk("stmem_done_cyc", 32'(cyc), 3);
        chk("stmem_no_iwe", {31'd0, iwe}, 0);
        chk("stmem_q_empty", 32'(ramq.size()), 0);

        // LD_MEM x=15 from 0x200
        for (int k = 0; k < 16; k++) set_mem(12'h200 + 12'(k), 8'(k ^ 8'hA5));
        for (int k = 0; k < 16; k++) regq.push_back({4'(k), 8'(k ^ 8'hA5)});
        run_job(XFER_LD_MEM, 4'd15, 12'h200, 1'b0, cyc, err, iwe, inew);
        chk("ldmem_done_cyc", 32'(cyc), 19);
        chk("ldmem_q_empty", 32'(regq.size()), 0);
        chk("ldmem_v9", {24'd0, rf[9]}, 32'(9 ^ 8'hA5));

        // ST_MEM wrap with I increment
        ramq.push_back({12'hFFF, 8'(0 ^ 8'hA5)});
        ramq.push_back({12'h000, 8'(1 ^ 8'hA5)});
        run_job(XFER_ST_MEM, 4'd1, 12'hFFF, 1'b1, cyc, err, iwe, inew);
        chk("wrap_done_cyc", 32'(cyc), 2);
        chk("wrap_iwe", {31'd0, iwe}, 1);
        chk("wrap_inew", {20'd0, inew}, 32'h001);
        chk("wrap_q_empty", 32'(ramq.size()), 0);

        // RPL round trip
        for (int k = 0; k < 8; k++) set_reg(k, rpl_val(k));
        run_job(XFER_ST_RPL, 4'd7, 12'h000, 1'b1, cyc, err, iwe, inew);
        chk("strpl_done_cyc", 32'(cyc), 8);
        chk("strpl_no_iwe", {31'd0, iwe}, 0);
        for (int k = 0; k < 8; k++) set_reg(k, 8'h00);
        for (int k = 0; k < 8; k++) regq.push_back({4'(k), rpl_val(k)});
        run_job(XFER_LD_RPL, 4'd7, 12'h000, 1'b0, cyc, err, iwe, inew);
        chk("ldrpl_done_cyc", 32'(cyc), 8);
        chk("ldrpl_err", {31'd0, err}, 0);
        chk("ldrpl_q_empty", 32'(regq.size()), 0);

        // RPL out of range
        run_job(XFER_LD_RPL, 4'd8, 12'h000, 1'b0, cyc, err, iwe, inew);
        chk("rplerr_done_cyc", 32'(cyc), 0);
        chk("rplerr_err", {31'd0, err}, 1);
        chk("rplerr_v0", {24'd0, rf[0]}, 32'(rpl_val(0)));

        // Reset on the third cycle of an LD_MEM
        for (int k = 0; k < 16; k++) set_reg(k, 8'h00);
        bus.op        = XFER_LD_MEM;
        bus.last_reg  = 4'd15;
        bus.base_addr = 12'h200;
        bus.inc_i     = 1'b0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b0;
        #1;
        chk("abort_outputs",
            {28'd0, bus.busy, bus.ram_en, bus.reg_we, bus.done}, 0);
        @(negedge clk);
        res_n = 1'b1;
        repeat (5) @(negedge clk);
        acc = '0;
        for (int k = 0; k < 16; k++) acc = acc | rf[k];
        chk("abort_no_wb", {24'd0, acc}, 0);
        set_reg(0, 8'h5A);
        ramq.push_back({12'h010, 8'h5A});
        run_job(XFER_ST_MEM, 4'd0, 12'h010, 1'b0, cyc, err, iwe, inew);
        chk("post_abort_cyc", 32'(cyc), 1);
        chk("post_abort_q", 32'(ramq.size()), 0);

        // start held high: one job per IDLE acceptance
        set_reg(0, 8'h77);
        ramq.push_back({12'h050, 8'h77});
        ramq.push_back({12'h050, 8'h77});
        bus.op        = XFER_ST_MEM;
        bus.last_reg  = 4'd0;
        bus.base_addr = 12'h050;
        bus.start     = 1'b1;
        @(negedge clk);
        chk("hold_c0", {30'd0, bus.busy, bus.ram_en}, 3);
        @(negedge clk);
        chk("hold_c1_done", {30'd0, bus.busy, bus.done}, 3);
        @(negedge clk);
        chk("hold_c2_idle", {31'd0, bus.busy}, 0);
        @(negedge clk);
        chk("hold_c3_job2", {30'd0, bus.busy, bus.ram_en}, 3);
        bus.start = 1'b0;
        @(negedge clk);
        chk("hold_c4_done", {31'd0, bus.done}, 1);
        @(negedge clk);
        @(negedge clk);
        chk("hold_c6_idle", {31'd0, bus.busy}, 0);
        chk("hold_q_empty", 32'(ramq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
